// File: rtl/seq_divider_pkg.sv
// Shared types and defaults for the sequential restoring divider.
// Imported by the top and the iteration step.
package seq_divider_pkg;

    localparam int DEF_DIVIDEND_W = 8;
    localparam int DEF_DIVISOR_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W = cnt_w(DEF_DIVIDEND_W);

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it fits.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int DIVISOR_W = DEF_DIVISOR_W
) (
    input  logic [DIVISOR_W-1:0] r,
    input  logic                 qmsb,
    input  logic [DIVISOR_W-1:0] d,
    output logic [DIVISOR_W-1:0] r_next,
    output logic                 qbit
);

    // t carries one extra bit for the shifted-in carry
    logic [DIVISOR_W:0] t;
    logic [DIVISOR_W:0] diff;

    always_comb begin
        t      = {r, qmsb};
        diff   = t - {1'b0, d};
        qbit   = (t >= {1'b0, d});
        r_next = qbit ? diff[DIVISOR_W-1:0] : t[DIVISOR_W-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider with start/done handshake.
// One quotient bit per cycle; divide-by-zero flagged, not iterated.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CW = cnt_w(DIVIDEND_W);
    localparam logic [CW-1:0] LAST = CW'(DIVIDEND_W - 1);

    state_t                state;
    logic [DIVIDEND_W-1:0] q;
    logic [DIVISOR_W-1:0]  r;
    logic [DIVISOR_W-1:0]  d;
    logic [CW-1:0]         cnt;

    logic [DIVISOR_W-1:0]  r_next;
    logic                  qbit;
    logic [DIVIDEND_W-1:0] q_next;

    div_step #(
        .DIVISOR_W(DIVISOR_W)
    ) u_step (
        .r      (r),
        .qmsb   (q[DIVIDEND_W-1]),
        .d      (d),
        .r_next (r_next),
        .qbit   (qbit)
    );

    assign q_next = {q[DIVIDEND_W-2:0], qbit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            q           <= '0;
            r           <= '0;
            d           <= '0;
            cnt         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        q     <= dividend;
                        d     <= divisor;
                        r     <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // zero divisor skips iterations after one cycle
                    if (d == '0) begin
                        quotient    <= '1;
                        remainder   <= '0;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        q   <= q_next;
                        r   <= r_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            quotient    <= q_next;
                            remainder   <= r_next;
                            div_by_zero <= 1'b0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
